// File: rtl/gcl_sched.sv
// gcl_sched: steps through a time-aware gate schedule held in the GCL RAM,
// one power-of-two-length slot at a time, prefetching the next RAM word
// while the current one is in use.
module gcl_sched #(
    parameter int BASE_SHIFT = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         test_start,
    input  logic         test_stop,
    input  logic         cnt_rst,
    input  logic [3:0]   slot_shift_cnt,
    input  logic [8:0]   last_slot,
    output logic         gcl_rd,
    output logic [4:0]   gcl_addr,
    input  logic [127:0] gcl_word,
    output logic [7:0]   gate_state,
    output logic         gate_valid,
    output logic [8:0]   slot_ID,
    output logic         slot_tick,
    output logic [31:0]  cycle_cnt
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t       state_q;
    logic [3:0]   shift_q;
    logic [8:0]   last_q;
    logic [127:0] cur_q, pf_q;
    logic [21:0]  cnt_q;
    logic         rvld_q;   // RAM data on gcl_word belongs to us this cycle
    logic         pend_q;   // a new word just became current; prefetch next
    logic         rd_q, valid_q, tick_q;
    logic [4:0]   addr_q;
    logic [7:0]   gate_q;
    logic [8:0]   slot_q;
    logic [31:0]  cyc_q;

    logic [4:0]   sh_amt;
    logic [21:0]  slot_max;
    logic         slot_end, word_chg, cyc_inc;
    logic [8:0]   slot_d;
    logic [127:0] word_d;
    logic [4:0]   pf_addr;

    assign sh_amt   = 5'(BASE_SHIFT) + {1'b0, shift_q};
    assign slot_max = (22'd1 << sh_amt) - 22'd1;
    assign slot_end = (cnt_q == slot_max);
    assign slot_d   = (slot_q == last_q) ? 9'd0 : slot_q + 9'd1;
    assign word_chg = (slot_d[8:4] != slot_q[8:4]);
    assign word_d   = word_chg ? pf_q : cur_q;
    // The next word after the last one in use wraps back to word 0
    assign pf_addr  = (slot_q[8:4] == last_q[8:4]) ? 5'd0 : slot_q[8:4] + 5'd1;
    assign cyc_inc  = (state_q == RUN) && !test_stop && slot_end && (slot_q == last_q);

    // Schedule FSM: start/stop control, slot timing, word fetch and prefetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            last_q  <= '0;
            cur_q   <= '0;
            pf_q    <= '0;
            cnt_q   <= '0;
            rvld_q  <= 1'b0;
            pend_q  <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            tick_q  <= 1'b0;
            gate_q  <= 8'hFF;
            slot_q  <= '0;
        end else begin
            rd_q   <= 1'b0;
            tick_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (test_start && !test_stop) begin
                        state_q <= LOAD;
                        shift_q <= slot_shift_cnt;
                        last_q  <= last_slot;
                        rd_q    <= 1'b1;
                        addr_q  <= 5'd0;
                    end
                end
                LOAD: begin
                    if (test_stop) begin
                        state_q <= IDLE;
                        rvld_q  <= 1'b0;
                    end else if (rvld_q) begin
                        state_q <= RUN;
                        rvld_q  <= 1'b0;
                        cur_q   <= gcl_word;
                        gate_q  <= gcl_word[7:0];
                        slot_q  <= 9'd0;
                        valid_q <= 1'b1;
                        tick_q  <= 1'b1;
                        cnt_q   <= '0;
                        pend_q  <= 1'b1;
                    end else begin
                        rvld_q <= rd_q;
                    end
                end
                RUN: begin
                    if (test_stop) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        gate_q  <= 8'hFF;
                        slot_q  <= '0;
                        cnt_q   <= '0;
                        rvld_q  <= 1'b0;
                        pend_q  <= 1'b0;
                    end else begin
                        rvld_q <= rd_q;
                        if (rvld_q) pf_q <= gcl_word;
                        if (pend_q) begin
                            rd_q   <= 1'b1;
                            addr_q <= pf_addr;
                            pend_q <= 1'b0;
                        end
                        if (slot_end) begin
                            cnt_q  <= '0;
                            slot_q <= slot_d;
                            gate_q <= word_d[{slot_d[3:0], 3'b000} +: 8];
                            tick_q <= 1'b1;
                            if (word_chg) begin
                                cur_q  <= pf_q;
                                pend_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 22'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Completed-schedule counter; a clear beats a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cyc_q <= '0;
        else if (cnt_rst) cyc_q <= '0;
        else if (cyc_inc) cyc_q <= cyc_q + 32'd1;
    end

    assign gcl_rd     = rd_q;
    assign gcl_addr   = addr_q;
    assign gate_state = gate_q;
    assign gate_valid = valid_q;
    assign slot_ID    = slot_q;
    assign slot_tick  = tick_q;
    assign cycle_cnt  = cyc_q;
endmodule

// File: tb/tb_gcl_sched.sv
// tb_gcl_sched: table of schedule configurations plus hand-written corner
// sequences; expected slot ticks are queued at start and popped on slot_tick.
module tb_gcl_sched;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic         test_start = 1'b0, test_stop = 1'b0, cnt_rst = 1'b0;
    logic [3:0]   slot_shift_cnt = '0;
    logic [8:0]   last_slot = '0;
    logic         gcl_rd;
    logic [4:0]   gcl_addr;
    logic [127:0] gcl_word = '0;
    logic [7:0]   gate_state;
    logic         gate_valid;
    logic [8:0]   slot_ID;
    logic         slot_tick;
    logic [31:0]  cycle_cnt;

    gcl_sched #(.BASE_SHIFT(6)) dut (
        .clk(clk), .rst_n(rst_n), .test_start(test_start), .test_stop(test_stop),
        .cnt_rst(cnt_rst), .slot_shift_cnt(slot_shift_cnt), .last_slot(last_slot),
        .gcl_rd(gcl_rd), .gcl_addr(gcl_addr), .gcl_word(gcl_word),
        .gate_state(gate_state), .gate_valid(gate_valid), .slot_ID(slot_ID),
        .slot_tick(slot_tick), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    // RAM model: data only valid the cycle after a read, garbage otherwise
    logic [127:0] mem [32];
    always @(posedge clk) begin
        if (gcl_rd) gcl_word <= mem[gcl_addr];
        else        gcl_word <= {$urandom(), $urandom(), $urandom(), $urandom()};
    end

    typedef struct {
        logic [8:0] slot;
        logic [7:0] gate;
        int         len;   // cycles since previous tick, 0 = don't check
    } tick_t;

    typedef struct {
        logic [3:0] shift;
        logic [8:0] last;
        int         nticks;
        int         exp_cyc;
        int         exp_rds;
        logic [4:0] exp_pf;
    } vec_t;

    tick_t      exp_q[$];
    logic [4:0] rd_log[$];
    int         n_cmp = 0, n_err = 0;
    int         cyc = 0, last_tick = 0, rd_cnt = 0;
    logic       rd_prev = 1'b0, seen_valid = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_gate(input logic [8:0] s);
        logic [127:0] w;
        w = mem[s[8:4]];
        return w[{s[3:0], 3'b000} +: 8];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every slot_tick must match the next queued slot
    always @(negedge clk) begin
        if (rst_n && slot_tick) begin
            if (exp_q.size() == 0) begin
                chk("tick_unexpected", {23'd0, slot_ID}, 32'h1FF);
            end else begin
                tick_t e;
                e = exp_q.pop_front();
                chk("tick_slot", {23'd0, slot_ID}, {23'd0, e.slot});
                chk("tick_gate", {24'd0, gate_state}, {24'd0, e.gate});
                chk("tick_valid", {31'd0, gate_valid}, 32'd1);
                if (e.len != 0) chk("tick_len", cyc - last_tick, e.len);
            end
            last_tick = cyc;
        end
    end

    // Read monitor: one-cycle read pulses, address log
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_prev = 1'b0;
        end else begin
            if (gcl_rd) begin
                chk("rd_single", {31'd0, rd_prev}, 32'd0);
                rd_cnt++;
                rd_log.push_back(gcl_addr);
            end
            rd_prev = gcl_rd;
        end
        if (gate_valid) seen_valid = 1'b1;
    end

    task automatic wait_q(input string nm, input int left, input int bound);
        int k = 0;
        while (exp_q.size() > left && k < bound) begin
            @(negedge clk); #1;
            k++;
        end
        chk({"wait_", nm}, exp_q.size(), left);
    endtask

    task automatic check_rst(input string p);
        chk({p, "_rd"},    {31'd0, gcl_rd},     32'd0);
        chk({p, "_addr"},  {27'd0, gcl_addr},   32'd0);
        chk({p, "_gate"},  {24'd0, gate_state}, 32'hFF);
        chk({p, "_valid"}, {31'd0, gate_valid}, 32'd0);
        chk({p, "_slot"},  {23'd0, slot_ID},    32'd0);
        chk({p, "_tick"},  {31'd0, slot_tick},  32'd0);
        chk({p, "_cyc"},   cycle_cnt,           32'd0);
    endtask

    task automatic push_ticks(input logic [3:0] sh, input logic [8:0] last, input int n);
        for (int i = 0; i < n; i++) begin
            logic [8:0] s;
            s = 9'(i % (int'(last) + 1));
            exp_q.push_back('{s, exp_gate(s), (i == 0) ? 0 : (64 << sh)});
        end
    endtask

    task automatic start_pulse();
        test_start = 1'b1;
        @(negedge clk);
        test_start = 1'b0;
    endtask

    task automatic run_cfg(input vec_t v);
        cnt_rst = 1'b1;
        @(negedge clk);
        cnt_rst = 1'b0;
        rd_cnt = 0;
        rd_log.delete();
        slot_shift_cnt = v.shift;
        last_slot = v.last;
        push_ticks(v.shift, v.last, v.nticks);
        start_pulse();                       // now in cycle T+1
        chk("load_rd", {31'd0, gcl_rd}, 32'd1);
        chk("load_addr", {27'd0, gcl_addr}, 32'd0);
        @(negedge clk);                      // T+2
        chk("pre_valid", {31'd0, gate_valid}, 32'd0);
        @(negedge clk);                      // T+3
        chk("first_valid", {31'd0, gate_valid}, 32'd1);
        chk("first_tick", {31'd0, slot_tick}, 32'd1);
        wait_q("run", 0, v.nticks * (64 << v.shift) + 100);
        repeat (10) @(negedge clk);
        chk("cyc_cnt", cycle_cnt, v.exp_cyc);
        test_stop = 1'b1;
        @(negedge clk);
        test_stop = 1'b0;
        chk("stop_valid", {31'd0, gate_valid}, 32'd0);
        chk("stop_gate", {24'd0, gate_state}, 32'hFF);
        chk("stop_slot", {23'd0, slot_ID}, 32'd0);
        chk("rd_count", rd_cnt, v.exp_rds);
        chk("pf_addr", {27'd0, rd_log[1]}, {27'd0, v.exp_pf});
    endtask

    vec_t vecs[4];

    initial begin
        for (int w = 0; w < 32; w++) begin
            logic [127:0] t;
            for (int k = 0; k < 16; k++) t[8*k +: 8] = 8'((w * 16 + k) * 7 + 3);
            mem[w] = t;
        end
        mem[0][7:0]     = 8'h01;
        mem[0][15:8]    = 8'h02;
        mem[0][23:16]   = 8'h03;
        mem[0][127:120] = 8'h0F;
        mem[1][7:0]     = 8'hA0;
        mem[1][15:8]    = 8'hA1;

        repeat (3) @(negedge clk);
        check_rst("reset");
        rst_n = 1'b1;
        @(negedge clk);

        //            shift  last  ticks cyc rds pf
        vecs[0] = '{4'd0, 9'd2,   7, 2, 2, 5'd0};
        vecs[1] = '{4'd0, 9'd17, 20, 1, 4, 5'd1};
        vecs[2] = '{4'd3, 9'd1,   3, 1, 2, 5'd0};
        vecs[3] = '{4'd0, 9'd0,   4, 3, 2, 5'd0};
        for (int i = 0; i < 4; i++) begin
            run_cfg(vecs[i]);
            if (vecs[i].last == 9'd17) begin
                chk("wrap_rd_addr0", {27'd0, rd_log[2]}, 32'd0);
                chk("wrap_rd_addr1", {27'd0, rd_log[3]}, 32'd1);
            end
            repeat (3) @(negedge clk);
        end

        // Simultaneous start and stop from IDLE: nothing happens
        rd_cnt = 0; seen_valid = 1'b0;
        test_start = 1'b1; test_stop = 1'b1;
        @(negedge clk);
        test_start = 1'b0; test_stop = 1'b0;
        repeat (10) @(negedge clk);
        chk("ss_rd", rd_cnt, 0);
        chk("ss_valid", {31'd0, seen_valid}, 32'd0);

        // Stop during LOAD: back to IDLE, gate_valid never rises
        rd_cnt = 0; seen_valid = 1'b0;
        slot_shift_cnt = 4'd0; last_slot = 9'd2;
        start_pulse();
        test_stop = 1'b1;
        @(negedge clk);
        test_stop = 1'b0;
        repeat (10) @(negedge clk);
        chk("ls_rd", rd_cnt, 1);
        chk("ls_valid", {31'd0, seen_valid}, 32'd0);

        // cnt_rst coinciding with a wrap (last_slot = 0)
        cnt_rst = 1'b1;
        @(negedge clk);
        cnt_rst = 1'b0;
        slot_shift_cnt = 4'd0; last_slot = 9'd0;
        push_ticks(4'd0, 9'd0, 4);
        start_pulse();
        wait_q("cr1", 3, 200);
        wait_q("cr2", 2, 200);
        chk("cr_before", cycle_cnt, 1);
        repeat (63) @(negedge clk);
        cnt_rst = 1'b1;
        @(negedge clk); #1;
        cnt_rst = 1'b0;
        chk("cr_tick", {31'd0, slot_tick}, 32'd1);
        chk("cr_clear", cycle_cnt, 0);
        wait_q("cr3", 0, 200);
        chk("cr_after", cycle_cnt, 1);
        test_stop = 1'b1;
        @(negedge clk);
        test_stop = 1'b0;

        // Asynchronous reset mid-run
        slot_shift_cnt = 4'd0; last_slot = 9'd2;
        push_ticks(4'd0, 9'd2, 2);
        start_pulse();
        wait_q("rs", 0, 300);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_rst("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0; rd_cnt = 0;
        repeat (80) @(negedge clk);
        chk("rst_idle_valid", {31'd0, seen_valid}, 32'd0);
        chk("rst_idle_rd", rd_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
